// File: rtl/tdm_par_buffer_pkg.sv
// tdm_par_pkg: shared partition constants, label type and count-width helper
package tdm_par_pkg;
    localparam int NPAR = 2;
    typedef logic par_t;
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/tdm_par_buffer_if.sv
// tdm_par_buffer_if: two-partition ingress ports plus the shared TDM output port
interface tdm_par_buffer_if import tdm_par_pkg::*; #(parameter int WIDTH = 8);
    logic [NPAR-1:0]  in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [NPAR-1:0]  in_ready;
    par_t             slot;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    modport master(output in_valid, in_data0, in_data1, out_ready,
                   input in_ready, slot, out_valid, out_data);
    modport slave(input in_valid, in_data0, in_data1, out_ready,
                  output in_ready, slot, out_valid, out_data);
endinterface

// File: rtl/tdm_par_buffer_fifo.sv
// par_fifo: single-partition FIFO; all state driven by its own push/pop only
module par_fifo import tdm_par_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;
    assign ready   = count < CW'(DEPTH);
    assign valid   = count != '0;
    assign do_push = push && ready;
    assign do_pop  = pop && valid;
    // an empty FIFO presents zero rather than stale storage
    assign head    = valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push && !reset) mem[wr_ptr] <= push_data;
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) count <= CW'(DEPTH));
endmodule

// File: rtl/tdm_par_buffer.sv
// tdm_par_buffer: two partition FIFOs sharing one output, time-multiplexed by a public slot counter
module tdm_par_buffer import tdm_par_pkg::*; #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int SLOT_LEN = 4
) (
    input logic clk,
    input logic reset,
    tdm_par_buffer_if.slave bus
);
    localparam int SW = SLOT_LEN > 1 ? $clog2(SLOT_LEN) : 1;
    logic [SW-1:0]    slot_cnt;
    par_t             slot;
    logic [NPAR-1:0]  rdy, vld;
    logic [WIDTH-1:0] head [NPAR];
    // schedule depends on clk/reset alone, so it carries no partition information
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
            slot     <= '0;
        end else if (slot_cnt == SW'(SLOT_LEN - 1)) begin
            slot_cnt <= '0;
            slot     <= ~slot;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end
    for (genvar i = 0; i < NPAR; i++) begin : g_par
        par_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk(clk),
            .reset(reset),
            .push(bus.in_valid[i]),
            .push_data(i == 0 ? bus.in_data0 : bus.in_data1),
            .pop(bus.out_ready && slot == par_t'(i)),
            .ready(rdy[i]),
            .valid(vld[i]),
            .head(head[i])
        );
    end
    assign bus.in_ready  = rdy;
    assign bus.slot      = slot;
    assign bus.out_valid = vld[slot];
    assign bus.out_data  = head[slot];
endmodule
